// File: rtl/rv32_instr_encoder.sv
// Encodes decoded RV32I field sets into 32-bit instruction words and streams
// them through a small first-word-fall-through FIFO into instruction memory.
module rv32_instr_encoder #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_start,
    input  logic [AW-1:0] load_base,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_last,
    input  logic [4:0]    in_op,
    input  logic [2:0]    in_funct3,
    input  logic          in_funct7_6,
    input  logic [4:0]    in_rd,
    input  logic [4:0]    in_rs1,
    input  logic [4:0]    in_rs2,
    input  logic [31:0]   in_imm,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    output logic [31:0]   imem_wdata,
    input  logic          imem_gnt,
    output logic          done,
    output logic          err_illegal,
    output logic [15:0]   wr_count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_IMM    = 5'b00100;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_REG    = 5'b01100;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_JAL    = 5'b11011;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_e;

    state_e         state_q, state_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [15:0]    wr_count_q, wr_count_d;
    logic           err_q, err_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [31:0]    mem_q [DEPTH];

    logic [24:0]    enc_body;
    logic           enc_legal;
    logic [31:0]    enc_word;
    logic           fifo_full;
    logic           fifo_empty;
    logic           accept;
    logic           push;
    logic           pop;

    // Field packing for everything above instr[6:0]
    always_comb begin
        enc_body  = 25'h0;
        enc_legal = 1'b1;
        case (in_op)
            OP_REG:    enc_body = {1'b0, in_funct7_6, 5'b0, in_rs2, in_rs1, in_funct3, in_rd};
            OP_IMM: begin
                if (in_funct3 == 3'b001 || in_funct3 == 3'b101)
                    enc_body = {1'b0, in_funct7_6, 5'b0, in_imm[4:0], in_rs1, in_funct3, in_rd};
                else
                    enc_body = {in_imm[11:0], in_rs1, in_funct3, in_rd};
            end
            OP_LOAD:   enc_body = {in_imm[11:0], in_rs1, in_funct3, in_rd};
            OP_JALR:   enc_body = {in_imm[11:0], in_rs1, 3'b000, in_rd};
            OP_STORE:  enc_body = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0]};
            OP_BRANCH: enc_body = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                                   in_imm[4:1], in_imm[11]};
            OP_LUI,
            OP_AUIPC:  enc_body = {in_imm[31:12], in_rd};
            OP_JAL:    enc_body = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd};
            default:   enc_legal = 1'b0;
        endcase
    end

    assign enc_word   = {enc_body, in_op, 2'b11};
    assign fifo_full  = (count_q == CW'(DEPTH));
    assign fifo_empty = (count_q == CW'(0));
    assign in_ready   = (state_q == S_RUN) && !fifo_full;
    assign accept     = in_valid && in_ready;
    assign push       = accept && enc_legal;
    assign pop        = !fifo_empty && imem_gnt;

    assign imem_req    = !fifo_empty;
    assign imem_addr   = addr_q;
    assign imem_wdata  = fifo_empty ? 32'h0 : mem_q[rd_ptr_q];
    assign done        = (state_q == S_DONE);
    assign err_illegal = err_q;
    assign wr_count    = wr_count_q;

    // Next-state: FIFO bookkeeping first, session control may override addr/count
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wr_count_d = wr_count_q;
        err_d      = err_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            addr_d   = addr_q + AW'(4);
            if (wr_count_q != 16'hFFFF)
                wr_count_d = wr_count_q + 16'd1;
        end
        if (push)
            wr_ptr_d = wr_ptr_q + PW'(1);

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            S_IDLE: begin
                if (load_start) begin
                    state_d    = S_RUN;
                    addr_d     = load_base & ~AW'(3);
                    wr_count_d = 16'h0;
                    err_d      = 1'b0;
                end
            end
            S_RUN: begin
                if (accept) begin
                    if (!enc_legal)
                        err_d = 1'b1;
                    if (in_last)
                        state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (fifo_empty)
                    state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            wr_count_q <= 16'h0;
            err_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wr_count_q <= wr_count_d;
            err_q      <= err_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty
    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= enc_word;
    end

endmodule

// File: tb/tb_rv32_instr_encoder.sv
// Table-driven bench for rv32_instr_encoder with a write scoreboard, plus
// hand-written backpressure, illegal-op, address-wrap and reset sequences.
module tb_rv32_instr_encoder;

    typedef struct {
        logic        first;
        logic [11:0] base;
        logic        last;
        logic [4:0]  op;
        logic [2:0]  f3;
        logic        f76;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] exp;
        logic        legal;
    } vec_t;

    localparam int NV = 15;

    logic        clk;
    logic        rst_n;
    logic        load_start;
    logic        load_start_w;
    logic [11:0] load_base;
    logic        in_valid;
    logic        in_last;
    logic [4:0]  in_op;
    logic [2:0]  in_funct3;
    logic        in_funct7_6;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] in_imm;
    logic        gnt;

    logic        in_ready;
    logic        imem_req;
    logic [11:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        done;
    logic        err_illegal;
    logic [15:0] wr_count;

    logic        w_in_ready;
    logic        w_imem_req;
    logic [5:0]  w_imem_addr;
    logic [31:0] w_imem_wdata;
    logic        w_done;
    logic        w_err_illegal;
    logic [15:0] w_wr_count;

    int          n_vec;
    int          n_err;
    int          n_wr;
    int          acc_cnt;
    int          done_cnt;
    int          w_done_cnt;
    logic        last_acc;
    logic        last_acc_w;
    logic        gnt_rand;
    logic [31:0] cur_exp;
    logic        cur_legal;
    logic [11:0] exp_addr;
    logic        hold_v;
    logic [11:0] hold_addr;
    logic [31:0] hold_data;
    logic [31:0] sb [$];
    logic [37:0] w_log [$];
    vec_t        vecs [NV];

    rv32_instr_encoder #(.DEPTH(4), .AW(12)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_start  (load_start),
        .load_base   (load_base),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_last     (in_last),
        .in_op       (in_op),
        .in_funct3   (in_funct3),
        .in_funct7_6 (in_funct7_6),
        .in_rd       (in_rd),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .in_imm      (in_imm),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .imem_gnt    (gnt),
        .done        (done),
        .err_illegal (err_illegal),
        .wr_count    (wr_count)
    );

    rv32_instr_encoder #(.DEPTH(4), .AW(6)) u_wrap (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_start  (load_start_w),
        .load_base   (load_base[5:0]),
        .in_valid    (in_valid),
        .in_ready    (w_in_ready),
        .in_last     (in_last),
        .in_op       (in_op),
        .in_funct3   (in_funct3),
        .in_funct7_6 (in_funct7_6),
        .in_rd       (in_rd),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .in_imm      (in_imm),
        .imem_req    (w_imem_req),
        .imem_addr   (w_imem_addr),
        .imem_wdata  (w_imem_wdata),
        .imem_gnt    (gnt),
        .done        (w_done),
        .err_illegal (w_err_illegal),
        .wr_count    (w_wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Negedge observation: writes/accepts seen here take effect at the next posedge
    task automatic sample();
        logic [31:0] e;
        if (!rst_n) begin
            hold_v = 1'b0;
            sb.delete();
        end else begin
            if (hold_v) begin
                check("hold_req", 32'(imem_req), 32'd1);
                check("hold_addr", 32'(imem_addr), 32'(hold_addr));
                check("hold_wdata", imem_wdata, hold_data);
            end
            hold_v    = imem_req && !gnt;
            hold_addr = imem_addr;
            hold_data = imem_wdata;
            if (imem_req && gnt) begin
                n_wr++;
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_write: got 0x%08h at 0x%03h, expected no write",
                             imem_wdata, imem_addr);
                end else begin
                    e = sb.pop_front();
                    check("wdata", imem_wdata, e);
                    check("waddr", 32'(imem_addr), 32'(exp_addr));
                    exp_addr = exp_addr + 12'd4;
                end
            end
            if (in_valid && in_ready) begin
                acc_cnt++;
                if (cur_legal)
                    sb.push_back(cur_exp);
            end
            if (done)
                done_cnt++;
            if (w_imem_req && gnt)
                w_log.push_back({w_imem_addr, w_imem_wdata});
            if (w_done)
                w_done_cnt++;
        end
        last_acc   = rst_n && in_valid && in_ready;
        last_acc_w = rst_n && in_valid && w_in_ready;
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        if (gnt_rand)
            gnt = 1'($urandom_range(0, 1));
    endtask

    task automatic set_fields(input logic [4:0] op, input logic [2:0] f3, input logic f76,
                              input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [31:0] imm, input logic last, input logic [31:0] exp,
                              input logic legal);
        in_op       = op;
        in_funct3   = f3;
        in_funct7_6 = f76;
        in_rd       = rd;
        in_rs1      = rs1;
        in_rs2      = rs2;
        in_imm      = imm;
        in_last     = last;
        cur_exp     = exp;
        cur_legal   = legal;
        in_valid    = 1'b1;
    endtask

    function automatic logic [31:0] addi_x1(input int imm);
        return (32'(imm) << 20) | 32'h0000_0093;
    endfunction

    task automatic set_addi(input int imm, input logic last);
        set_fields(5'b00100, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'(imm), last, addi_x1(imm), 1'b1);
    endtask

    task automatic send(input logic to_wrap);
        logic ok;
        ok = 1'b0;
        for (int c = 0; c < 40 && !ok; c++) begin
            tick();
            ok = to_wrap ? last_acc_w : last_acc;
        end
        check("accept", 32'(ok), 32'd1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic start_session(input logic [11:0] base);
        load_base  = base;
        load_start = 1'b1;
        exp_addr   = base & 12'hFFC;
        acc_cnt    = 0;
        done_cnt   = 0;
        tick();
        load_start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, input int exp_wc);
        for (int c = 0; c < max_cyc && done_cnt == 0; c++)
            tick();
        tick();
        tick();
        check("done_pulses", 32'(done_cnt), 32'd1);
        check("wr_count", 32'(wr_count), 32'(exp_wc));
        check("sb_empty", 32'(sb.size()), 32'd0);
        check("idle_in_ready", 32'(in_ready), 32'd0);
    endtask

    initial begin
        int sess_wc;
        int i;
        int wr_snap;
        logic [37:0] wl;

        vecs[0]  = '{1'b1, 12'h100, 1'b0, 5'b01100, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'h0000_0000, 32'h0020_81B3, 1'b1};
        vecs[1]  = '{1'b0, 12'h000, 1'b0, 5'b01100, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'h0000_0000, 32'h4020_81B3, 1'b1};
        vecs[2]  = '{1'b0, 12'h000, 1'b1, 5'b00100, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'hFFF0_0093, 1'b1};
        vecs[3]  = '{1'b1, 12'h207, 1'b0, 5'b01000, 3'd2, 1'b0, 5'd5, 5'd1, 5'd2, 32'h0000_0008, 32'h0020_A423, 1'b1};
        vecs[4]  = '{1'b0, 12'h000, 1'b0, 5'b11000, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 32'hFE20_8EE3, 1'b1};
        vecs[5]  = '{1'b0, 12'h000, 1'b0, 5'b11011, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h0000_0008, 32'h0080_00EF, 1'b1};
        vecs[6]  = '{1'b0, 12'h000, 1'b1, 5'b00100, 3'd5, 1'b1, 5'd5, 5'd5, 5'd0, 32'h0000_0003, 32'h4032_D293, 1'b1};
        vecs[7]  = '{1'b1, 12'h400, 1'b0, 5'b01101, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_52B7, 1'b1};
        vecs[8]  = '{1'b0, 12'h000, 1'b0, 5'b00101, 3'd0, 1'b0, 5'd7, 5'd0, 5'd0, 32'hABCD_E123, 32'hABCD_E397, 1'b1};
        vecs[9]  = '{1'b0, 12'h000, 1'b0, 5'b00000, 3'd2, 1'b0, 5'd4, 5'd2, 5'd0, 32'hFFFF_FFF8, 32'hFF81_2203, 1'b1};
        vecs[10] = '{1'b0, 12'h000, 1'b0, 5'b11001, 3'd7, 1'b0, 5'd1, 5'd6, 5'd0, 32'h0000_0010, 32'h0103_00E7, 1'b1};
        vecs[11] = '{1'b0, 12'h000, 1'b0, 5'b00100, 3'd1, 1'b0, 5'd2, 5'd3, 5'd0, 32'h0000_003F, 32'h01F1_9113, 1'b1};
        vecs[12] = '{1'b0, 12'h000, 1'b0, 5'b00100, 3'd7, 1'b1, 5'd8, 5'd9, 5'd0, 32'h0000_07FF, 32'h7FF4_F413, 1'b1};
        vecs[13] = '{1'b0, 12'h000, 1'b0, 5'b11000, 3'd1, 1'b0, 5'd0, 5'd3, 5'd4, 32'h0000_0800, 32'h0041_90E3, 1'b1};
        vecs[14] = '{1'b0, 12'h000, 1'b1, 5'b11011, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFE, 32'hFFFF_F06F, 1'b1};

        n_vec = 0; n_err = 0; n_wr = 0; acc_cnt = 0; done_cnt = 0; w_done_cnt = 0;
        rst_n = 1'b0; load_start = 1'b0; load_start_w = 1'b0; load_base = 12'h0;
        in_valid = 1'b0; in_last = 1'b0; in_op = 5'h0; in_funct3 = 3'h0; in_funct7_6 = 1'b0;
        in_rd = 5'h0; in_rs1 = 5'h0; in_rs2 = 5'h0; in_imm = 32'h0;
        gnt = 1'b1; gnt_rand = 1'b0; cur_exp = 32'h0; cur_legal = 1'b0;
        exp_addr = 12'h0; hold_v = 1'b0; hold_addr = 12'h0; hold_data = 32'h0;
        last_acc = 1'b0; last_acc_w = 1'b0;

        #3;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_imem_addr", 32'(imem_addr), 32'd0);
        check("rst_imem_wdata", imem_wdata, 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err_illegal", 32'(err_illegal), 32'd0);
        check("rst_wr_count", 32'(wr_count), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Encoding table, three sessions; the third runs under random grants
        sess_wc = 0;
        for (int k = 0; k < NV; k++) begin
            if (vecs[k].first) begin
                gnt_rand = (k == 7);
                start_session(vecs[k].base);
                sess_wc = 0;
            end
            set_fields(vecs[k].op, vecs[k].f3, vecs[k].f76, vecs[k].rd, vecs[k].rs1, vecs[k].rs2,
                       vecs[k].imm, vecs[k].last, vecs[k].exp, vecs[k].legal);
            send(1'b0);
            if (vecs[k].legal)
                sess_wc++;
            if (vecs[k].last) begin
                gnt_rand = 1'b0;
                gnt      = 1'b1;
                wait_done(200, sess_wc);
            end
        end

        // Backpressure: six words offered while grant is withheld for ten cycles
        start_session(12'h300);
        gnt = 1'b0;
        i = 0;
        set_addi(0, 1'b0);
        for (int cyc = 0; cyc < 80 && i < 6; cyc++) begin
            if (cyc == 10) begin
                check("bp_accepted", 32'(acc_cnt), 32'd4);
                check("bp_in_ready", 32'(in_ready), 32'd0);
                check("bp_req", 32'(imem_req), 32'd1);
                check("bp_addr", 32'(imem_addr), 32'h300);
                check("bp_wdata", imem_wdata, addi_x1(0));
                gnt = 1'b1;
            end
            tick();
            if (last_acc) begin
                i++;
                if (i < 6)
                    set_addi(i, (i == 5));
                else begin
                    in_valid = 1'b0;
                    in_last  = 1'b0;
                end
            end
        end
        check("bp_all_accepted", 32'(i), 32'd6);
        wait_done(100, 6);

        // Illegal op as the last entry: accepted, not written, sticky error
        start_session(12'h500);
        set_addi(5, 1'b0);
        send(1'b0);
        set_fields(5'b11111, 3'd0, 1'b0, 5'd1, 5'd2, 5'd3, 32'h0, 1'b1, 32'h0, 1'b0);
        send(1'b0);
        set_addi(6, 1'b0);
        wait_done(40, 1);
        in_valid = 1'b0;
        check("ill_accepted", 32'(acc_cnt), 32'd2);
        check("ill_err", 32'(err_illegal), 32'd1);
        start_session(12'h600);
        check("ill_err_cleared", 32'(err_illegal), 32'd0);
        set_addi(7, 1'b1);
        send(1'b0);
        wait_done(40, 1);

        // Address wrap on the narrow-address instance
        w_log.delete();
        w_done_cnt   = 0;
        load_base    = 12'h03C;
        load_start_w = 1'b1;
        tick();
        load_start_w = 1'b0;
        set_addi(1, 1'b0);
        send(1'b1);
        set_addi(2, 1'b1);
        send(1'b1);
        for (int c = 0; c < 40 && w_done_cnt == 0; c++)
            tick();
        tick();
        check("wrap_writes", 32'(w_log.size()), 32'd2);
        check("wrap_done", 32'(w_done_cnt), 32'd1);
        check("wrap_wr_count", 32'(w_wr_count), 32'd2);
        if (w_log.size() == 2) begin
            wl = w_log[0];
            check("wrap_addr0", 32'(wl[37:32]), 32'h3C);
            check("wrap_data0", wl[31:0], addi_x1(1));
            wl = w_log[1];
            check("wrap_addr1", 32'(wl[37:32]), 32'h00);
            check("wrap_data1", wl[31:0], addi_x1(2));
        end

        // Reset mid-session with three words stalled in the FIFO
        start_session(12'h700);
        gnt = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_addi(k + 8, 1'b0);
            send(1'b0);
        end
        tick();
        check("pre_rst_req", 32'(imem_req), 32'd1);
        check("pre_rst_wr_count", 32'(wr_count), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_req", 32'(imem_req), 32'd0);
        check("rst_mid_in_ready", 32'(in_ready), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_in_ready", 32'(in_ready), 32'd0);
        check("post_rst_wr_count", 32'(wr_count), 32'd0);
        check("post_rst_req", 32'(imem_req), 32'd0);
        gnt = 1'b1;
        wr_snap = n_wr;
        repeat (6) tick();
        check("post_rst_no_write", 32'(n_wr - wr_snap), 32'd0);

        // Normal session still works after the reset
        start_session(12'h800);
        set_addi(11, 1'b1);
        send(1'b0);
        wait_done(40, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
